// File: rtl/data_memory_responder.sv
// Data memory responder: word-organised RAM behind a stall/done handshake.
// Accepted accesses take LATENCY busy cycles. Lanes are big-endian and sub-word
// loads can be sign- or zero-extended. Misaligned, illegal-size and
// out-of-range requests are refused with a one-cycle AddrErr_out pulse.
//
// state | meaning
// IDLE  | waiting for a request; stall asserted combinationally on a legal one
// BUSY  | access in flight, counter runs down to zero, inputs ignored
// DONE  | access complete, Done_out high, stall released for one cycle
module data_memory_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic [31:0] Address_in,
  input  logic [31:0] WriteData_in,
  input  logic [1:0]  MemSize_in,
  input  logic        Unsigned_in,
  output logic        Mem_Stall_out,
  output logic [31:0] ReadData_out,
  output logic        Done_out,
  output logic        AddrErr_out
);

  localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] MEM_BYTES = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [3:0]  CNT_LOAD  = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] mem [DEPTH_WORDS];

  logic [AW-1:0] idx_q;
  logic [1:0]    off_q;
  logic [31:0]   wdata_q;
  logic [1:0]    size_q;
  logic          wr_q;
  logic          uns_q;

  logic        req, bad_align, reject, accept, commit;
  logic [31:0] word_cur, word_new, lane_data, load_val;
  logic [3:0]  lane_en;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  // Request classification and the combinational stall seen by the pipeline.
  always_comb begin
    req       = MemRead_in | MemWrite_in;
    bad_align = ((MemSize_in == 2'b00) && (Address_in[1:0] != 2'b00)) ||
                ((MemSize_in == 2'b01) && Address_in[0]) ||
                (MemSize_in == 2'b11);
    reject    = req && (bad_align || ({1'b0, Address_in} >= MEM_BYTES));
    accept    = (state == IDLE) && req && !reject;
    commit    = (state == BUSY) && (cnt == 4'd0);
    // Reset must release the pipeline even if a request is sitting on the inputs.
    Mem_Stall_out = Rst_n && (accept || (state == BUSY));
  end

  // Byte-lane merge for stores and lane extraction/extension for loads.
  always_comb begin
    word_cur  = mem[idx_q];
    lane_en   = 4'b1111;
    lane_data = wdata_q;
    case (size_q)
      2'b00: begin
        lane_en   = 4'b1111;
        lane_data = wdata_q;
      end
      2'b01: begin
        lane_en   = off_q[1] ? 4'b0011 : 4'b1100;
        lane_data = {2{wdata_q[15:0]}};
      end
      default: begin
        lane_en   = 4'b1000 >> off_q;
        lane_data = {4{wdata_q[7:0]}};
      end
    endcase
    word_new = word_cur;
    for (int i = 0; i < 4; i++) begin
      if (lane_en[i]) word_new[8*i +: 8] = lane_data[8*i +: 8];
    end
    // Offset 0 is the most significant lane, so shift by (3 - offset) bytes.
    rd_byte = 8'(word_cur >> {~off_q, 3'b000});
    rd_half = off_q[1] ? word_cur[15:0] : word_cur[31:16];
    case (size_q)
      2'b00:   load_val = word_cur;
      2'b01:   load_val = uns_q ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: load_val = uns_q ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
    endcase
  end

  // Sequencer: capture on accept, count down in BUSY, pulse Done/AddrErr.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      ReadData_out <= 32'd0;
      Done_out     <= 1'b0;
      AddrErr_out  <= 1'b0;
      idx_q        <= '0;
      off_q        <= 2'd0;
      wdata_q      <= 32'd0;
      size_q       <= 2'd0;
      wr_q         <= 1'b0;
      uns_q        <= 1'b0;
    end else begin
      Done_out    <= 1'b0;
      AddrErr_out <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state   <= BUSY;
            cnt     <= CNT_LOAD;
            idx_q   <= Address_in[AW+1:2];
            off_q   <= Address_in[1:0];
            wdata_q <= WriteData_in;
            size_q  <= MemSize_in;
            wr_q    <= MemWrite_in;
            uns_q   <= Unsigned_in;
          end else if (reject) begin
            AddrErr_out <= 1'b1;
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            state    <= DONE;
            Done_out <= 1'b1;
            if (!wr_q) ReadData_out <= load_val;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Storage is never reset; a write lands only on the BUSY->DONE edge, so a
  // reset during BUSY (which forces IDLE at once) drops it.
  always_ff @(posedge Clk) begin
    if (commit && wr_q) mem[idx_q] <= word_new;
  end

endmodule

// File: doc/data_memory_responder.md
DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning number of 32-bit words stored (power of two).
REQ-002 SHALL have parameter LATENCY, default 2, meaning BUSY cycles per access (legal range 1..15).
REQ-003 SHALL have port Clk  input  1  sole clock; all state changes on posedge.
REQ-004 SHALL have port Rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port MemRead_in  input  1  read request, held by the upstream EX/MEM register while stalled.
REQ-006 SHALL have port MemWrite_in  input  1  write request, held likewise.
REQ-007 SHALL have port Address_in  input  32  byte address.
REQ-008 SHALL have port WriteData_in  input  32  store data; sub-word stores use low bits.
REQ-009 SHALL have port MemSize_in  input  2  access size: 00 word, 01 half, 10 byte, 11 illegal.
REQ-010 SHALL have port Unsigned_in  input  1  1 = zero-extend sub-word loads, 0 = sign-extend.
REQ-011 SHALL have port Mem_Stall_out  output  1  freezes the pipeline while high.
REQ-012 SHALL have port ReadData_out  output  32  registered load result.
REQ-013 SHALL have port Done_out  output  1  one-cycle pulse at access completion.
REQ-014 SHALL have port AddrErr_out  output  1  one-cycle pulse on a rejected request.

Function
REQ-015 SHALL implement the states IDLE, BUSY and DONE, plus a 4-bit down-counter.
REQ-016 SHALL treat a request as MemRead_in or MemWrite_in high; when both are high, the write SHALL take precedence and ReadData_out SHALL stay unchanged.
REQ-017 SHALL classify a request as rejected when any of these holds: word with Address_in[1:0]!=0; half with Address_in[0]=1; MemSize_in=11; Address_in >= DEPTH_WORDS*4.
REQ-018 SHALL, in IDLE, drive Mem_Stall_out combinationally high when a non-rejected request is present.
REQ-019 SHALL, in IDLE with a non-rejected request at posedge, capture address, data, size, op and Unsigned_in, enter BUSY, and load the counter with LATENCY-1.
REQ-020 SHALL, in IDLE with a rejected request at posedge, pulse AddrErr_out high for the next cycle, stay in IDLE, leave memory unmodified and keep Mem_Stall_out low.
REQ-021 SHALL, in BUSY, hold Mem_Stall_out high, ignore all inputs, and decrement the counter each cycle; at posedge with counter=0 it SHALL go to DONE.
REQ-022 SHALL commit a write on the BUSY->DONE edge, changing only the addressed byte lanes.
REQ-023 SHALL load ReadData_out on that same edge with the extended read result.
REQ-024 SHALL use big-endian lanes: byte offset 0 = bits[31:24]; half offset 0 = bits[31:16].
REQ-025 SHALL, in DONE, drive Done_out=1 and Mem_Stall_out=0, ignore inputs (the same instruction is still presented), and go to IDLE at the next posedge.
REQ-026 SHALL give a total stall of LATENCY+1 cycles per accepted access, with Done_out high in cycle accept+LATENCY+1 counted from the first stalled cycle.
REQ-027 SHALL keep ReadData_out unchanged except on a completing read.
REQ-028 SHALL make a write followed by a read of the same address return the new data.

Reset
REQ-029 SHALL, while Rst_n=0, force state IDLE, counter 0, ReadData_out 0, Done_out 0, AddrErr_out 0 and Mem_Stall_out 0, independent of Clk.
REQ-030 SHALL discard a write pending in BUSY on reset assertion without modifying memory; a write already committed SHALL remain.
REQ-031 SHALL NOT clear memory contents on reset.
REQ-032 SHALL leave memory contents undefined at power-up.

Verification
REQ-033 SHALL cover: LATENCY=2, word write 0xDEADBEEF @0x10, then word read @0x10 -> stall high 3 cycles each, Done_out pulse each, ReadData_out=0xDEADBEEF.
REQ-034 SHALL cover: byte write 0x7F @0x11 over 0xDEADBEEF, then signed byte read @0x11 -> 0x0000007F; then word read -> 0xDE7FBEEF; then signed half read @0x10 -> 0xFFFFDE7F.
REQ-035 SHALL cover: word read @0x13, and half write @0x01, and MemSize_in=11 -> AddrErr_out pulse each, no stall, memory unchanged.
REQ-036 SHALL cover: MemRead_in and MemWrite_in both high, data 0x12345678 @0x20 -> write performed, ReadData_out unchanged.
REQ-037 SHALL cover: Rst_n low mid-BUSY during a write of 0x55 @0x30 -> outputs 0 immediately, IDLE, later read @0x30 returns prior contents.
REQ-038 SHALL cover: LATENCY=1 and LATENCY=15 back-to-back reads -> stall of 2 and 16 cycles respectively, with one IDLE cycle between accesses.
